// File: rtl/bp_pkg.sv
// bp_pkg: FSM encoding and default parameter constants shared by the trace driver.
package bp_pkg;
  localparam int ADDR_W_DEF     = 8;
  localparam int HIST_LEN_DEF   = 7;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int TIMEOUT_DEF    = 63;
  typedef enum logic [2:0] {
    WAIT_MEM, IDLE, ISSUE, WAIT_PRED, WAIT_DONE, RELEASE, HIST_REQ, HIST_CAP
  } bp_state_e;
endpackage

// File: rtl/bp_trace_fifo.sv
// bp_trace_fifo: synchronous FIFO with registered full/empty; push on full succeeds with a same-cycle pop.
module bp_trace_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign wr = push_i && (!full_o || pop_i);
  assign rd = pop_i && !empty_o;
  assign cnt_d = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_d;
      full_o  <= cnt_d == (AW+1)'(DEPTH);
      empty_o <= cnt_d == '0;
    end
  end
endmodule

// File: rtl/bp_trace_driver.sv
// bp_trace_driver: replays queued branch traces into a branch predictor, keeps
// accuracy/timeout statistics and serially captures the predictor history on request.
module bp_trace_driver
  import bp_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int HIST_LEN   = HIST_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_valid,
  output logic              trace_ready,
  input  logic [ADDR_W-1:0] trace_addr,
  input  logic              trace_taken,
  output logic [ADDR_W-1:0] bp_inst_addr,
  output logic              bp_new_data_avail,
  output logic              bp_direction,
  input  logic              bp_mem_reset_done,
  input  logic              bp_pred_ready,
  input  logic              bp_prediction,
  input  logic              bp_training_done,
  output logic              hist_req,
  input  logic              hist_bit,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [HIST_LEN:0] dump_data,
  output logic [CNT_W-1:0]  n_branches,
  output logic [CNT_W-1:0]  n_mispred,
  output logic [CNT_W-1:0]  n_timeouts,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(HIST_LEN + 2);
  bp_state_e state_q;
  logic [ADDR_W:0] head;
  logic full, empty, pop, dump_req, tmo;
  logic [ADDR_W-1:0] addr_q;
  logic dir_q, nda_q, hist_req_q, dump_valid_q, pend_q;
  logic [HIST_LEN:0] dump_q;
  logic [CNT_W-1:0] n_branches_q, n_mispred_q, n_timeouts_q;
  logic [TW-1:0] tmo_q;
  logic [BW-1:0] bidx_q;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign dump_req = dump_start || pend_q;
  assign pop = state_q == IDLE && !dump_req && !empty;
  assign tmo = tmo_q == TW'(TIMEOUT);
  // Gated by rst_n so every output reads 0 while reset is held.
  assign trace_ready = rst_n && !full;
  assign busy = rst_n && state_q != IDLE;
  assign bp_inst_addr = addr_q;
  assign bp_direction = dir_q;
  assign bp_new_data_avail = nda_q;
  assign hist_req = hist_req_q;
  assign dump_valid = dump_valid_q;
  assign dump_data = dump_q;
  assign n_branches = n_branches_q;
  assign n_mispred = n_mispred_q;
  assign n_timeouts = n_timeouts_q;
  bp_trace_fifo #(.W(ADDR_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(trace_valid && trace_ready),
    .din_i({trace_addr, trace_taken}), .pop_i(pop), .dout_o(head),
    .full_o(full), .empty_o(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_MEM;
      addr_q       <= '0;
      dir_q        <= 1'b0;
      nda_q        <= 1'b0;
      hist_req_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      dump_q       <= '0;
      n_branches_q <= '0;
      n_mispred_q  <= '0;
      n_timeouts_q <= '0;
      tmo_q        <= '0;
      bidx_q       <= '0;
    end else begin
      nda_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      pend_q       <= pend_q || dump_start;
      case (state_q)
        WAIT_MEM: if (bp_mem_reset_done) state_q <= IDLE;
        IDLE: begin
          if (dump_req) begin
            pend_q     <= 1'b0;
            hist_req_q <= 1'b1;
            state_q    <= HIST_REQ;
          end else if (!empty) begin
            {addr_q, dir_q} <= head;
            nda_q           <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT_PRED;
        end
        WAIT_PRED: begin
          tmo_q <= tmo_q + 1'b1;
          if (bp_pred_ready) begin
            if (bp_prediction != dir_q) n_mispred_q <= sat(n_mispred_q);
            if (bp_training_done) n_branches_q <= sat(n_branches_q);
            state_q <= bp_training_done ? RELEASE : WAIT_DONE;
          end else if (tmo) begin
            n_timeouts_q <= sat(n_timeouts_q);
            state_q      <= RELEASE;
          end
        end
        WAIT_DONE: begin
          tmo_q <= tmo_q + 1'b1;
          if (bp_training_done) begin
            n_branches_q <= sat(n_branches_q);
            state_q      <= RELEASE;
          end else if (tmo) begin
            n_timeouts_q <= sat(n_timeouts_q);
            state_q      <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        HIST_REQ: begin
          bidx_q  <= '0;
          state_q <= HIST_CAP;
        end
        HIST_CAP: begin
          // Shifting in from the top leaves the first serial bit at dump_data[0].
          hist_req_q <= 1'b0;
          dump_q     <= {hist_bit, dump_q[HIST_LEN:1]};
          bidx_q     <= bidx_q + 1'b1;
          if (bidx_q == BW'(HIST_LEN)) begin
            dump_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= WAIT_MEM;
      endcase
    end
  end
endmodule
